// File: rtl/alarm_sounder.sv
// Alarm sounder controller: rings, snoozes and times out one alarm event.
// Every output is registered, so an input change shows on the outputs after the next clock edge.
module alarm_sounder #(
   parameter int SNOOZE_SEC       = 300,
   parameter int RING_TIMEOUT_SEC = 60,
   parameter int MAX_SNOOZE       = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1s,
   input  logic       tick_beep,
   input  logic       alarm_triggered,
   input  logic       snooze_btn,
   input  logic       stop_btn,
   output logic       buzzer,
   output logic       stop_alarm,
   output logic [1:0] state,
   output logic [9:0] secs_left,
   output logic [1:0] snooze_used
);

   localparam logic [9:0] RING_LOAD   = 10'(RING_TIMEOUT_SEC);
   localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SEC);
   localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } state_t;

   state_t     state_reg, state_next;
   logic [9:0] secs_reg, secs_next;
   logic [1:0] used_reg, used_next;
   logic       phase_reg, phase_next;
   logic       buzzer_reg, buzzer_next;
   logic       stop_reg, stop_next;
   logic       snooze_ok;

   assign snooze_ok = (used_reg < SNOOZE_MAX);

   always_comb begin
      state_next = state_reg;
      secs_next  = secs_reg;
      used_next  = used_reg;
      phase_next = phase_reg;
      stop_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (alarm_triggered) begin
               state_next = RINGING;
               secs_next  = RING_LOAD;
               used_next  = 2'd0;
               phase_next = 1'b1;
            end
         end
         RINGING: begin
            if (stop_btn) begin
               state_next = IDLE;
               secs_next  = 10'd0;
               stop_next  = 1'b1;
            end else if (snooze_btn && snooze_ok) begin
               state_next = SNOOZE;
               secs_next  = SNOOZE_LOAD;
               used_next  = used_reg + 2'd1;
            end else begin
               // A refused snooze is a no-op, so a coincident tick still counts.
               if (tick_1s) begin
                  if (secs_reg > 10'd1) begin
                     secs_next = secs_reg - 10'd1;
                  end else if (snooze_ok) begin
                     state_next = SNOOZE;
                     secs_next  = SNOOZE_LOAD;
                     used_next  = used_reg + 2'd1;
                  end else begin
                     state_next = IDLE;
                     secs_next  = 10'd0;
                     stop_next  = 1'b1;
                  end
               end
               if (tick_beep && (state_next == RINGING)) begin
                  phase_next = ~phase_reg;
               end
            end
         end
         SNOOZE: begin
            if (stop_btn) begin
               state_next = IDLE;
               secs_next  = 10'd0;
               stop_next  = 1'b1;
            end else if (tick_1s) begin
               if (secs_reg > 10'd1) begin
                  secs_next = secs_reg - 10'd1;
               end else begin
                  state_next = RINGING;
                  secs_next  = RING_LOAD;
                  phase_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            secs_next  = 10'd0;
         end
      endcase
      buzzer_next = (state_next == RINGING) && phase_next;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= IDLE;
         secs_reg   <= 10'd0;
         used_reg   <= 2'd0;
         phase_reg  <= 1'b0;
         buzzer_reg <= 1'b0;
         stop_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         secs_reg   <= secs_next;
         used_reg   <= used_next;
         phase_reg  <= phase_next;
         buzzer_reg <= buzzer_next;
         stop_reg   <= stop_next;
      end
   end

   assign state       = state_reg;
   assign secs_left   = secs_reg;
   assign snooze_used = used_reg;
   assign buzzer      = buzzer_reg;
   assign stop_alarm  = stop_reg;

endmodule

// File: tb/tb_alarm_sounder.sv
// Directed bench for alarm_sounder with SNOOZE_SEC=5, RING_TIMEOUT_SEC=3, MAX_SNOOZE=2.
// Observed outputs are packed as {state, secs_left, snooze_used, buzzer, stop_alarm}.
module tb_alarm_sounder;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick_1s = 1'b0, tick_beep = 1'b0, alarm_triggered = 1'b0;
   logic       snooze_btn = 1'b0, stop_btn = 1'b0;
   logic       buzzer, stop_alarm;
   logic [1:0] state, snooze_used;
   logic [9:0] secs_left;
   logic [15:0] obs;
   int total = 0;
   int bad = 0;

   alarm_sounder #(.SNOOZE_SEC(5), .RING_TIMEOUT_SEC(3), .MAX_SNOOZE(2)) dut (
      .clk(clk), .reset(reset), .tick_1s(tick_1s), .tick_beep(tick_beep),
      .alarm_triggered(alarm_triggered), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
      .buzzer(buzzer), .stop_alarm(stop_alarm), .state(state),
      .secs_left(secs_left), .snooze_used(snooze_used)
   );

   always #5 clk = ~clk;
   assign obs = {state, secs_left, snooze_used, buzzer, stop_alarm};

   // One clock of stimulus; outputs are settled 1ns after the edge.
   task automatic step(input logic trig, input logic snz, input logic stp,
                       input logic t1, input logic tb);
      @(negedge clk);
      alarm_triggered = trig; snooze_btn = snz; stop_btn = stp;
      tick_1s = t1; tick_beep = tb;
      @(posedge clk);
      #1;
      alarm_triggered = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
      tick_1s = 1'b0; tick_beep = 1'b0;
      $display("t=%0t rst=%b in(trig,snz,stp,1s,beep)=%b%b%b%b%b -> st=%0d secs=%0d used=%0d buz=%b stop=%b",
               $time, reset, trig, snz, stp, t1, tb, state, secs_left, snooze_used, buzzer, stop_alarm);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      total++;
      if (obs !== 16'h0) begin bad++; $display("FAIL reset_state got=%h want=%h", obs, 16'h0); end
      reset = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (obs !== 16'h0) begin bad++; $display("FAIL idle_after_reset got=%h want=%h", obs, 16'h0); end
   endtask

   task automatic test_ring_beep();
      logic [15:0] want;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      want = {2'd1, 10'd3, 2'd0, 1'b1, 1'b0};
      total++;
      if (obs !== want) begin bad++; $display("FAIL ring_entry got=%h want=%h", obs, want); end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         want = {2'd1, 10'd3, 2'd0, 1'(i % 2), 1'b0};
         total++;
         if (obs !== want) begin bad++; $display("FAIL beep_%0d got=%h want=%h", i, obs, want); end
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      want = {2'd0, 10'd0, 2'd0, 1'b0, 1'b1};
      total++;
      if (obs !== want) begin bad++; $display("FAIL ring_stop got=%h want=%h", obs, want); end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (stop_alarm !== 1'b0) begin bad++; $display("FAIL stop_one_cycle got=%b want=0", stop_alarm); end
   endtask

   task automatic test_snooze();
      logic [15:0] want;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      want = {2'd2, 10'd5, 2'd1, 1'b0, 1'b0};
      total++;
      if (obs !== want) begin bad++; $display("FAIL snooze_entry got=%h want=%h", obs, want); end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         want = {2'd2, 10'(4 - i), 2'd1, 1'b0, 1'b0};
         total++;
         if (obs !== want) begin bad++; $display("FAIL snooze_count_%0d got=%h want=%h", i, obs, want); end
      end
      // Beep coincident with re-entry to RINGING must not flip the fresh phase.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      want = {2'd1, 10'd3, 2'd1, 1'b1, 1'b0};
      total++;
      if (obs !== want) begin bad++; $display("FAIL snooze_expire got=%h want=%h", obs, want); end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      want = {2'd1, 10'd3, 2'd1, 1'b0, 1'b0};
      total++;
      if (obs !== want) begin bad++; $display("FAIL beep_after_reentry got=%h want=%h", obs, want); end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      want = {2'd0, 10'd0, 2'd1, 1'b0, 1'b1};
      total++;
      if (obs !== want) begin bad++; $display("FAIL snooze_test_stop got=%h want=%h", obs, want); end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_auto_snooze();
      logic [15:0] want;
      int stops = 0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            stops += int'(stop_alarm);
            want = {2'd1, 10'(2 - i), 2'(r), 1'b1, 1'b0};
            total++;
            if (obs !== want) begin bad++; $display("FAIL auto_ring_r%0d_%0d got=%h want=%h", r, i, obs, want); end
         end
         step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         stops += int'(stop_alarm);
         want = (r < 2) ? {2'd2, 10'd5, 2'(r + 1), 1'b0, 1'b0} : {2'd0, 10'd0, 2'd2, 1'b0, 1'b1};
         total++;
         if (obs !== want) begin bad++; $display("FAIL auto_timeout_r%0d got=%h want=%h", r, obs, want); end
         if (r < 2) begin
            for (int i = 0; i < 5; i++) begin
               step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
               stops += int'(stop_alarm);
            end
            want = {2'd1, 10'd3, 2'(r + 1), 1'b1, 1'b0};
            total++;
            if (obs !== want) begin bad++; $display("FAIL auto_rering_r%0d got=%h want=%h", r, obs, want); end
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stops += int'(stop_alarm);
      total++;
      if (stops != 1) begin bad++; $display("FAIL auto_stop_pulses got=%0d want=1", stops); end
   endtask

   task automatic test_priority();
      logic [15:0] want;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      want = {2'd0, 10'd0, 2'd1, 1'b0, 1'b1};
      total++;
      if (obs !== want) begin bad++; $display("FAIL stop_beats_snooze got=%h want=%h", obs, want); end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      want = {2'd0, 10'd0, 2'd1, 1'b0, 1'b0};
      total++;
      if (obs !== want) begin bad++; $display("FAIL priority_idle_hold got=%h want=%h", obs, want); end
   endtask

   task automatic test_saturate();
      logic [15:0] want;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 2; r++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      want = {2'd1, 10'd2, 2'd2, 1'b1, 1'b0};
      total++;
      if (obs !== want) begin bad++; $display("FAIL sat_ring got=%h want=%h", obs, want); end
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (obs !== want) begin bad++; $display("FAIL sat_snooze_ignored got=%h want=%h", obs, want); end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (obs !== want) begin bad++; $display("FAIL trig_ignored_ringing got=%h want=%h", obs, want); end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      want = {2'd1, 10'd3, 2'd0, 1'b1, 1'b0};
      total++;
      if (obs !== want) begin bad++; $display("FAIL new_event_clears_used got=%h want=%h", obs, want); end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_snooze();
      logic [15:0] want;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      want = {2'd2, 10'd4, 2'd1, 1'b0, 1'b0};
      total++;
      if (obs !== want) begin bad++; $display("FAIL pre_reset_snooze got=%h want=%h", obs, want); end
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      total++;
      if (obs !== 16'h0) begin bad++; $display("FAIL reset_in_snooze got=%h want=%h", obs, 16'h0); end
      reset = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (obs !== 16'h0) begin bad++; $display("FAIL silent_after_reset got=%h want=%h", obs, 16'h0); end
   endtask

   initial begin
      test_reset();
      test_ring_beep();
      test_snooze();
      test_auto_snooze();
      test_priority();
      test_saturate();
      test_reset_snooze();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alarm_sounder.md
ALARM_SOUNDER -- requirements
Module: alarm_sounder

Interface
REQ-001 Parameter: SNOOZE_SEC, default 300, snooze length in seconds (1..1023).
REQ-002 Parameter: RING_TIMEOUT_SEC, default 60, ringing duration before timeout in seconds (1..1023).
REQ-003 Parameter: MAX_SNOOZE, default 3, snoozes allowed per alarm event (0..3).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; takes effect at a rising clk edge while low.
REQ-006 tick_1s  input  1  one-cycle pulse once per second.
REQ-007 tick_beep  input  1  one-cycle pulse at the beep toggle rate.
REQ-008 alarm_triggered  input  1  one-cycle pulse from alarm_trigger marking a new alarm event.
REQ-009 snooze_btn  input  1  one-cycle debounced snooze press.
REQ-010 stop_btn  input  1  one-cycle debounced stop press.
REQ-011 buzzer  output  1  registered buzzer drive.
REQ-012 stop_alarm  output  1  registered one-cycle pulse that clears alarm_trigger's alarm_active.
REQ-013 state  output  2  0=IDLE, 1=RINGING, 2=SNOOZE; 3 is never driven.
REQ-014 secs_left  output  10  seconds remaining in the current RINGING or SNOOZE period; 0 in IDLE.
REQ-015 snooze_used  output  2  snoozes consumed in the current event.

Function
REQ-016 All state changes and outputs SHALL be registered: an input sampled at edge N is reflected in outputs after edge N.
REQ-017 IDLE + alarm_triggered -> RINGING; secs_left=RING_TIMEOUT_SEC, snooze_used=0, beep phase=1.
REQ-018 alarm_triggered SHALL be ignored in RINGING and SNOOZE.
REQ-019 In RINGING, buzzer SHALL equal the beep phase, which toggles on each tick_beep; buzzer=0 in IDLE and SNOOZE.
REQ-020 RINGING + stop_btn -> IDLE, secs_left=0, with one stop_alarm pulse.
REQ-021 RINGING + snooze_btn with snooze_used<MAX_SNOOZE -> SNOOZE; secs_left=SNOOZE_SEC, snooze_used+1.
REQ-022 RINGING + snooze_btn with snooze_used==MAX_SNOOZE SHALL be ignored.
REQ-023 RINGING + tick_1s with secs_left>1 SHALL decrement secs_left.
REQ-024 RINGING + tick_1s with secs_left==1 (timeout) SHALL behave exactly as an accepted snooze_btn if snoozes remain, otherwise exactly as stop_btn.
REQ-025 SNOOZE + stop_btn -> IDLE with one stop_alarm pulse; snooze_btn SHALL be ignored.
REQ-026 SNOOZE + tick_1s with secs_left>1 SHALL decrement secs_left; with secs_left==1 -> RINGING, secs_left=RING_TIMEOUT_SEC, beep phase=1; snooze_used unchanged.
REQ-027 Same-cycle priority: stop_btn > snooze_btn > tick_1s; a lower-priority event coincident with a higher-priority one SHALL be discarded, not deferred.
REQ-028 tick_beep coincident with a state entry SHALL NOT toggle the freshly loaded phase.
REQ-029 stop_alarm SHALL be high exactly one cycle per transition to IDLE, except transitions caused by reset.
REQ-030 secs_left SHALL never underflow or wrap; it is 0 only in IDLE.
REQ-031 snooze_used SHALL saturate at MAX_SNOOZE and hold until the next alarm event or reset.

Reset
REQ-032 reset low at a clk edge SHALL force state=IDLE, buzzer=0, stop_alarm=0, secs_left=0, snooze_used=0, beep phase=0, regardless of all other inputs.
REQ-033 Reset during RINGING or SNOOZE SHALL cancel silently, with no stop_alarm pulse.

Verification (SNOOZE_SEC=5, RING_TIMEOUT_SEC=3, MAX_SNOOZE=2)
REQ-034 alarm_triggered pulse, then 4 tick_beep pulses -> state=1, secs_left=3, buzzer sequence 1,0,1,0,1.
REQ-035 RINGING, snooze_btn -> state=2, secs_left=5, snooze_used=1, buzzer=0; after 5 tick_1s -> state=1, secs_left=3.
REQ-036 3 tick_1s in RINGING three times, with no buttons -> two auto-snoozes (snooze_used=2), then IDLE with a single stop_alarm pulse.
REQ-037 snooze_btn and stop_btn in the same cycle during RINGING -> IDLE, stop_alarm=1 for one cycle, snooze_used unchanged.
REQ-038 snooze_used=2 in RINGING, snooze_btn -> stays RINGING, secs_left unchanged.
REQ-039 reset low during SNOOZE with secs_left=4 -> all outputs 0 next cycle, stop_alarm never asserted.
